// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: access widths, FSM states,
// requester encoding and the default BRAM address width.
package mem_arb_pkg;

   localparam int ADDR_W_DEFAULT = 12;

   // dm_width codes; 2'b11 is the illegal code
   localparam logic [1:0] BYTE = 2'b00;
   localparam logic [1:0] HALF = 2'b01;
   localparam logic [1:0] WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // An access is legal when its width code is defined and it is naturally aligned
   function automatic logic is_legal(input logic [1:0] width, input logic [1:0] addr_lo);
      logic ok;
      case (width)
         BYTE:    ok = 1'b1;
         HALF:    ok = ~addr_lo[0];
         WORD:    ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant between the fetch and data requesters.
// On a tie the requester that did not win last time is chosen.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   req_if,
   input  logic   req_dm,
   output logic   gnt_valid,
   output owner_e gnt_owner
);

   owner_e last_grant_q, last_grant_d;

   // Pick a winner from the current requests and the last grant
   always_comb begin
      gnt_valid = en & (req_if | req_dm);
      if (req_if && req_dm) begin
         gnt_owner = (last_grant_q == OWN_IF) ? OWN_DM : OWN_IF;
      end else if (req_dm) begin
         gnt_owner = OWN_DM;
      end else begin
         gnt_owner = OWN_IF;
      end
   end

   // Remember the winner of every grant that actually takes effect
   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt_valid) begin
         last_grant_d = gnt_owner;
      end
   end

   // Last-grant register; starts at IF so DM wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= OWN_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide dual-port BRAM between instruction fetch and data access.
// A word takes two beats (ports A/B carry bytes 0/1 then 2/3); byte and half
// accesses take one beat. Handshake: a requester holds req high until it sees
// its ack pulse; the ack cycle itself is ignored for that requester so a req
// still high from the finished transaction is not granted a second time.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_width,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ack,
   output logic              dm_err,
   output logic [31:0]       dm_rdata,
   output logic              busy,
   output logic              en_a,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [7:0]        data_a,
   output logic              en_b,
   output logic              we_b,
   output logic [ADDR_W-1:0] addr_b,
   output logic [7:0]        data_b,
   input  logic [7:0]        recv_data_a,
   input  logic [7:0]        recv_data_b,
   output state_e            dbg_state
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [1:0]        width_q, width_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d;
   logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, dm_err_q, dm_err_d;
   logic [31:0]       if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

   logic              gnt_valid;
   owner_e            gnt_owner;
   logic [1:0]        g_width;
   logic [31:0]       g_addr;
   logic              g_legal;
   logic [31:0]       rd_word;

   arb_rr2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (state_q == IDLE),
      .req_if    (if_req & ~if_ack_q),
      .req_dm    (dm_req & ~dm_ack_q),
      .gnt_valid (gnt_valid),
      .gnt_owner (gnt_owner)
   );

   // Attributes of whichever requester won this cycle; a fetch is always a word read
   always_comb begin
      if (gnt_owner == OWN_DM) begin
         g_width = dm_width;
         g_addr  = dm_addr;
      end else begin
         g_width = WORD;
         g_addr  = if_addr;
      end
      g_legal = is_legal(g_width, g_addr[1:0]);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; rejected requests never leave IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid && g_legal) state_d = BEAT0;
         BEAT0:   state_d = (width_q == WORD) ? BEAT1 : RESP;
         BEAT1:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: BRAM port drive per beat, plus busy/debug
   always_comb begin
      en_a   = 1'b0;
      we_a   = 1'b0;
      addr_a = '0;
      data_a = '0;
      en_b   = 1'b0;
      we_b   = 1'b0;
      addr_b = '0;
      data_b = '0;
      case (state_q)
         BEAT0: begin
            en_a   = 1'b1;
            we_a   = we_q;
            addr_a = addr_q;
            data_a = wdata_q[7:0];
            if (width_q != BYTE) begin
               en_b   = 1'b1;
               we_b   = we_q;
               addr_b = addr_q + ADDR_W'(1);
               data_b = wdata_q[15:8];
            end
         end
         BEAT1: begin
            en_a   = 1'b1;
            we_a   = we_q;
            addr_a = addr_q + ADDR_W'(2);
            data_a = wdata_q[23:16];
            en_b   = 1'b1;
            we_b   = we_q;
            addr_b = addr_q + ADDR_W'(3);
            data_b = wdata_q[31:24];
         end
         default: ;
      endcase
      busy      = (state_q != IDLE);
      dbg_state = state_q;
   end

   // Read word seen in RESP: the last beat's bytes are live on recv_data_*
   always_comb begin
      case (width_q)
         WORD:    rd_word = {recv_data_b, recv_data_a, b1_q, b0_q};
         HALF:    rd_word = {16'h0, recv_data_b, recv_data_a};
         default: rd_word = {24'h0, recv_data_a};
      endcase
   end

   // Transaction latch, first-beat capture and response generation
   always_comb begin
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      width_d    = width_q;
      wdata_d    = wdata_q;
      b0_d       = b0_q;
      b1_d       = b1_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      dm_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               if (g_legal) begin
                  owner_d = gnt_owner;
                  addr_d  = g_addr[ADDR_W-1:0];
                  width_d = g_width;
                  we_d    = (gnt_owner == OWN_DM) & dm_we;
                  wdata_d = (gnt_owner == OWN_DM) ? dm_wdata : 32'h0;
               end else if (gnt_owner == OWN_DM) begin
                  dm_ack_d = 1'b1;
                  dm_err_d = 1'b1;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = 32'h0;
               end
            end
         end
         BEAT1: begin
            b0_d = recv_data_a;
            b1_d = recv_data_b;
         end
         RESP: begin
            if (owner_q == OWN_IF) begin
               if_ack_d   = 1'b1;
               if_rdata_d = rd_word;
            end else begin
               dm_ack_d = 1'b1;
               if (!we_q) begin
                  dm_rdata_d = rd_word;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         width_q    <= BYTE;
         wdata_q    <= '0;
         b0_q       <= '0;
         b1_q       <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         dm_err_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         width_q    <= width_d;
         wdata_q    <= wdata_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         dm_err_q   <= dm_err_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign if_ack   = if_ack_q;
   assign if_rdata = if_rdata_q;
   assign dm_ack   = dm_ack_q;
   assign dm_err   = dm_err_q;
   assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte-array BRAM model, a transaction-level
// reference memory, directed scenarios and a randomized mix.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW     = 12;
   localparam int MEM_SZ = 1 << AW;

   logic          clk, rst;
   logic          if_req, if_ack;
   logic [31:0]   if_addr, if_rdata;
   logic          dm_req, dm_we, dm_ack, dm_err;
   logic [1:0]    dm_width;
   logic [31:0]   dm_addr, dm_wdata, dm_rdata;
   logic          busy, en_a, we_a, en_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [7:0]    data_a, data_b, recv_data_a, recv_data_b;
   state_e        dbg_state;

   logic [7:0]    bram    [MEM_SZ];
   logic [7:0]    ref_mem [MEM_SZ];
   logic [31:0]   exp_dm_rd;
   int            n_checks, n_errors;

   mem_port_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_width(dm_width), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
      .busy(busy),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
      .recv_data_a(recv_data_a), .recv_data_b(recv_data_b),
      .dbg_state(dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte-wide dual-port BRAM, read data one cycle after enable
   always @(posedge clk) begin
      if (en_a) begin
         if (we_a) bram[addr_a] <= data_a;
         recv_data_a <= bram[addr_a];
      end
      if (en_b) begin
         if (we_b) bram[addr_b] <= data_b;
         recv_data_b <= bram[addr_b];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference rules
   function automatic int nbytes(input logic [1:0] w);
      return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit legal_acc(input logic [1:0] w, input logic [31:0] a);
      if (w == 2'b11) return 1'b0;
      return (a % nbytes(w)) == 0;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) % MEM_SZ];
      return v;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {if_ack, dm_ack, dm_err, busy, en_a, en_b, we_a, we_b}, 0);
      check({tag, "_bram"}, {addr_a, addr_b, data_a, data_b}, 0);
      check({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      exp_dm_rd = '0;
   endtask

   // One transaction: drive, wait (bounded) for ack, check against the reference.
   // extra = cycles spent waiting behind the other requester.
   task automatic do_txn(input bit is_if, input bit we, input logic [1:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int extra, input bit drop_early, input bit chk_side);
      logic [1:0]  w;
      bit          legal, saw_a, saw_b, got_err;
      int          lat, exp_lat, nbusy, n;
      logic [31:0] got_rd, exp_rd;
      string       pfx;
      pfx     = is_if ? "if" : "dm";
      w       = is_if ? 2'b10 : width;
      legal   = legal_acc(w, addr);
      n       = nbytes(w);
      exp_lat = (legal ? ((n == 4) ? 4 : 3) : 1) + extra;
      if (is_if) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         dm_req   = 1'b1;
         dm_we    = we;
         dm_width = width;
         dm_addr  = addr;
         dm_wdata = wdata;
      end
      lat = -1; nbusy = 0; saw_a = 0; saw_b = 0; got_err = 0; got_rd = '0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         saw_a = saw_a | en_a;
         saw_b = saw_b | en_b;
         if (busy) nbusy++;
         if ((is_if && if_ack) || (!is_if && dm_ack)) begin
            lat     = k;
            got_err = dm_err;
            got_rd  = is_if ? if_rdata : dm_rdata;
            break;
         end
         @(posedge clk); #1;
         if (drop_early && k == 0) begin
            if (is_if) if_req = 1'b0; else dm_req = 1'b0;
         end
      end
      @(posedge clk); #1;
      if (is_if) if_req = 1'b0; else dm_req = 1'b0;

      check({pfx, "_lat"}, lat, exp_lat);
      check({pfx, "_err"}, got_err, !is_if && !legal);
      if (is_if) begin
         exp_rd = legal ? mem_read(addr, 4) : 32'h0;
         check("if_rdata", got_rd, exp_rd);
      end else if (legal) begin
         if (!we) exp_dm_rd = mem_read(addr, n);
         check("dm_rdata", got_rd, exp_dm_rd);
         if (we) for (int i = 0; i < n; i++) ref_mem[(addr + i) % MEM_SZ] = wdata[8*i +: 8];
      end
      if (chk_side) begin
         check({pfx, "_en_a"}, saw_a, legal);
         check({pfx, "_en_b"}, saw_b, legal && n > 1);
         check({pfx, "_busy"}, nbusy, legal ? exp_lat - 1 : 0);
      end
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Main sequence
   initial begin
      int acks, gap;
      bit r_if;
      logic [1:0] r_w;
      logic [31:0] r_a;
      n_checks = 0; n_errors = 0; exp_dm_rd = '0;
      for (int i = 0; i < MEM_SZ; i++) begin
         bram[i] <= 8'h0;
         ref_mem[i] = 8'h0;
      end
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_width = 0; dm_addr = 0; dm_wdata = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 check_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Word write then read back
      do_txn(0, 1, WORD, 32'h010, 32'hDEADBEEF, 0, 0, 1);
      check("bram_010", {bram[12'h013], bram[12'h012], bram[12'h011], bram[12'h010]}, 32'hDEADBEEF);
      do_txn(0, 0, WORD, 32'h010, 0, 0, 0, 1);
      check("dm_rd_hold", dm_rdata, 32'hDEADBEEF);
      do_txn(1, 0, WORD, 32'h010, 0, 0, 0, 1);
      do_txn(1, 0, WORD, 32'h012, 0, 0, 0, 1);

      // Misaligned half rejected
      do_txn(0, 0, HALF, 32'h013, 0, 0, 0, 1);

      // Byte at the top of the lower half, port B never enabled
      do_txn(0, 1, BYTE, 32'h7FF, 32'hFFFFFF5A, 0, 0, 1);
      do_txn(0, 0, BYTE, 32'h7FF, 0, 0, 0, 1);
      check("byte_rd", dm_rdata, 32'h0000005A);

      // Request dropped during BEAT0 still completes
      do_txn(0, 0, WORD, 32'h010, 0, 0, 1, 1);

      // Tie out of reset: DM first, IF follows in DM's ack cycle
      apply_reset();
      fork
         do_txn(1, 0, WORD, 32'h010, 0, 4, 0, 0);
         do_txn(0, 0, WORD, 32'h014, 0, 0, 0, 1);
      join
      // DM wins alone, then the next tie goes to IF
      do_txn(0, 1, WORD, 32'h014, 32'h12345678, 0, 0, 1);
      fork
         do_txn(1, 0, WORD, 32'h014, 0, 0, 0, 1);
         do_txn(0, 0, HALF, 32'h016, 0, 4, 0, 0);
      join

      // Reset during BEAT1 of a fetch abandons it
      if_req = 1'b1; if_addr = 32'h010;
      @(posedge clk); @(posedge clk); #2;
      check("st_beat1", dbg_state, BEAT1);
      rst = 1'b0;
      #1 check_zero("rst_mid");
      if_req = 1'b0;
      acks = 0;
      repeat (2) begin @(negedge clk); acks += int'(if_ack); end
      @(posedge clk); #1 rst = 1'b1;
      exp_dm_rd = '0;
      repeat (3) begin @(negedge clk); acks += int'(if_ack); end
      check("no_if_ack", acks, 0);
      @(posedge clk); #1;
      do_txn(1, 0, WORD, 32'h010, 0, 0, 0, 1);

      // Randomized mix of widths, alignments, directions and high address bits
      for (int t = 0; t < 60; t++) begin
         r_if = ($urandom_range(0, 3) == 0);
         r_w  = 2'($urandom_range(0, 3));
         r_a  = $urandom & 32'hFFFF_F03F;
         if ($urandom_range(0, 3) != 0) begin
            if (r_if || r_w == WORD) r_a[1:0] = 2'b00;
            else if (r_w == HALF) r_a[0] = 1'b0;
         end
         do_txn(r_if, 1'($urandom_range(0, 1)), r_w, r_a, $urandom, 0, 0, 1);
         gap = $urandom_range(0, 2);
         repeat (gap) begin @(posedge clk); #1; end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the BRAM byte-address width; request address bits above ADDR_W-1 are ignored.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch request; a level held until if_ack.
REQ-005 SHALL have port if_addr, input, 32, instruction-fetch byte address; every fetch is a word read.
REQ-006 SHALL have port if_ack, output, 1, one-cycle completion pulse for an instruction fetch.
REQ-007 SHALL have port if_rdata, output, 32, fetched word, little-endian; valid while if_ack is high.
REQ-008 SHALL have port dm_req, input, 1, data request; a level held until dm_ack.
REQ-009 SHALL have port dm_we, input, 1, data write (1) or read (0).
REQ-010 SHALL have port dm_width, input, 2, access width: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port dm_addr, input, 32, data byte address.
REQ-012 SHALL have port dm_wdata, input, 32, write data, little-endian, LSB-aligned.
REQ-013 SHALL have port dm_ack, output, 1, one-cycle completion pulse for a data request.
REQ-014 SHALL have port dm_err, output, 1, pulses together with dm_ack when the access was rejected.
REQ-015 SHALL have port dm_rdata, output, 32, read data, zero-extended; valid while dm_ack is high.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE; used as the pipeline stall input.
REQ-017 SHALL have BRAM port A outputs: en_a (1), we_a (1), addr_a (ADDR_W) and data_a (8).
REQ-018 SHALL have BRAM port B outputs: en_b (1), we_b (1), addr_b (ADDR_W) and data_b (8).
REQ-019 SHALL have BRAM read-data inputs recv_data_a and recv_data_b (8 each), valid one cycle after the port is enabled.

Function
REQ-020 SHALL implement the FSM states IDLE, BEAT0, BEAT1, RESP.
- IDLE -> BEAT0 on a granted legal request.
- BEAT0 -> BEAT1 if the access is a word, otherwise -> RESP.
- BEAT1 -> RESP.
- RESP -> IDLE.
REQ-021 SHALL arbitrate in IDLE only.
- A single requester wins.
- When both request, the requester not granted last wins (2-way round-robin); last_grant resets to IF, so DM wins the first tie.
REQ-022 SHALL latch owner, address, we, width and wdata at grant; input changes after grant are ignored.
REQ-023 SHALL drive the BRAM ports per state:
- BEAT0: port A = byte addr+0, port B = byte addr+1.
- BEAT1: port A = addr+2, port B = addr+3.
- A byte access drives port A only, with en_b=0.
REQ-024 SHALL capture read data one cycle after each beat: BEAT0 data in BEAT1/RESP, BEAT1 data in RESP.
REQ-025 SHALL pulse the owner's ack in the cycle after RESP. Latency from req sampled in IDLE cycle T is:
- word: ack at T+4;
- byte/half: ack at T+3.
Writes have the same latency; rdata holds its previous value on writes.
REQ-026 SHALL reject a misaligned word (addr[1:0]!=0), a misaligned half (addr[0]=1) or width 11:
- no BRAM enable;
- ack and err pulse at T+1;
- FSM stays in IDLE.
REQ-027 SHALL treat an IF request with if_addr[1:0]!=0 as a misaligned word and ack it with if_rdata=0.
REQ-028 SHALL complete and ack a granted transaction even if its req drops mid-transaction.
REQ-029 SHALL evaluate a new request in the same IDLE cycle in which a previous ack is pulsing; back-to-back grants are allowed.
REQ-030 SHALL wrap the address modulo 2^ADDR_W; no access crosses the top, given the alignment rules.

Reset
REQ-031 SHALL on rst low asynchronously force:
- FSM to IDLE and last_grant to IF;
- all acks, err, busy, en_a/en_b and we_a/we_b to 0;
- rdata, addr and data outputs to 0.
REQ-032 SHALL abandon an in-flight transaction on reset with no ack; the requester re-issues it after reset.

Structure
REQ-033 SHALL take from shared package mem_arb_pkg:
- the width codes (BYTE, HALF, WORD);
- the state enum;
- the owner encoding;
- the ADDR_W default.
REQ-034 SHALL contain one sub-module arb_rr2 (2-way round-robin grant with a last_grant flop); the rest is inline FSM.

Verification
REQ-035 SHALL test: DM word write 0xDEADBEEF at 0x010, then word read 0x010 -> bytes 0x010..0x013 = EF,BE,AD,DE; dm_rdata=0xDEADBEEF; ack at T+4.
REQ-036 SHALL test: if_req and dm_req both high out of reset -> DM granted first, IF granted in the IDLE cycle of DM's ack pulse; a second tie grants IF.
REQ-037 SHALL test: DM half read at 0x013 -> dm_ack and dm_err at T+1; en_a=en_b=0 throughout.
REQ-038 SHALL test: DM byte write 0x5A at 0x7FF, then byte read -> dm_rdata=0x0000005A; en_b never asserted.
REQ-039 SHALL test: rst low during BEAT1 of an IF fetch -> all outputs 0, no if_ack; re-issued fetch acks correctly.
REQ-040 SHALL test: dm_req dropped in BEAT0 -> dm_ack still pulses at T+4; busy high from T+1 to T+3.
